sqrt_controller: RTL

SQRT_CONTROLLER -- requirements
Module: sqrt_controller

---
 rtl/sqrt_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sqrt_controller.sv
// Sequencing controller for an integer square-root engine built on an external
// register file + ALU datapath. Uses the odd-number subtraction method:
// repeatedly subtract 1, 3, 5, ... from N and count the successful
// subtractions; the count is floor(sqrt(N)).
//
// Register map used by the sequence:
//   R0 = remainder, R1 = current odd number, R2 = count, R3 = 2, R4 = 1.
//
// All outputs are decoded from the state register only, with one exception:
// in SUB the write enable and the next state also depend on the ALU flags.
// A failed subtraction (negative result) is therefore never written back.
module sqrt_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic                  negative_i,
    input  logic                  zero_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  IE_o,
    output logic                  WE_o,
    output logic                  OE_o,
    output logic [2:0]            ADDR_WR_o,
    output logic [2:0]            ADDR_RDA_o,
    output logic [2:0]            ADDR_RDB_o,
    output logic [1:0]            ALU_Op_o,
    output logic [DATA_WIDTH-1:0] dp_data_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_LD0  = 4'd1;   // R0 <- N
    localparam logic [3:0] S_LD1  = 4'd2;   // R1 <- 1
    localparam logic [3:0] S_LD3  = 4'd3;   // R3 <- 2
    localparam logic [3:0] S_LD4  = 4'd4;   // R4 <- 1
    localparam logic [3:0] S_LD2  = 4'd5;   // R2 <- 0
    localparam logic [3:0] S_SUB  = 4'd6;   // R0 <- R0 - R1 (if not negative)
    localparam logic [3:0] S_INC  = 4'd7;   // R2 <- R2 + R4
    localparam logic [3:0] S_ODD  = 4'd8;   // R1 <- R1 + R3
    localparam logic [3:0] S_OUT  = 4'd9;   // out <- R2 & R2
    localparam logic [3:0] S_DONE = 4'd10;

    // Register-file addresses
    localparam logic [2:0] R_REM   = 3'd0;
    localparam logic [2:0] R_ODD   = 3'd1;
    localparam logic [2:0] R_COUNT = 3'd2;
    localparam logic [2:0] R_TWO   = 3'd3;
    localparam logic [2:0] R_ONE   = 3'd4;

    // ALU operation codes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    localparam int MSB = DATA_WIDTH - 1;

    logic [3:0]            state;
    logic [3:0]            next_state;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  zero_seen_q;
    logic                  accept;

    // A request is only taken while idle; starts during a run are dropped.
    assign accept = (state == S_IDLE) && start_i;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // State register; reset returns to IDLE without waiting for a clock edge.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand holding register: loaded once on acceptance, stable for the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_q <= '0;
        end else if (accept) begin
            operand_q <= operand_i;
        end
    end

    // Remember whether the last subtraction hit exactly zero; INC uses it to
    // finish a perfect square without a further, failing subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_seen_q <= 1'b0;
        end else if (state == S_SUB) begin
            zero_seen_q <= zero_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Sequence: load constants, then SUB/INC/ODD loop until the remainder
    // would go negative (or reached zero), then publish the count.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned; a missing default here is what infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    // Negative operands skip the datapath entirely.
                    next_state = operand_i[MSB] ? S_DONE : S_LD0;
                end
            end
            S_LD0:  next_state = S_LD1;
            S_LD1:  next_state = S_LD3;
            S_LD3:  next_state = S_LD4;
            S_LD4:  next_state = S_LD2;
            S_LD2:  next_state = S_SUB;
            S_SUB:  next_state = negative_i ? S_OUT : S_INC;
            S_INC:  next_state = zero_seen_q ? S_OUT : S_ODD;
            S_ODD:  next_state = S_SUB;
            S_OUT:  next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------

    // Datapath controls per state; everything not listed for a state is 0.
    always_comb begin
        busy_o     = (state != S_IDLE);
        done_o     = 1'b0;
        err_o      = 1'b0;
        IE_o       = 1'b0;
        WE_o       = 1'b0;
        OE_o       = 1'b0;
        ADDR_WR_o  = 3'd0;
        ADDR_RDA_o = 3'd0;
        ADDR_RDB_o = 3'd0;
        ALU_Op_o   = OP_ADD;
        dp_data_o  = '0;
        case (state)
            S_LD0: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = R_REM;
                dp_data_o = operand_q;
            end
            S_LD1: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = R_ODD;
                dp_data_o = DATA_WIDTH'(1);
            end
            S_LD3: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = R_TWO;
                dp_data_o = DATA_WIDTH'(2);
            end
            S_LD4: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = R_ONE;
                dp_data_o = DATA_WIDTH'(1);
            end
            S_LD2: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = R_COUNT;
                dp_data_o = '0;
            end
            S_SUB: begin
                // Only commit the subtraction when it did not underflow.
                ALU_Op_o   = OP_SUB;
                ADDR_RDA_o = R_REM;
                ADDR_RDB_o = R_ODD;
                ADDR_WR_o  = R_REM;
                WE_o       = !negative_i;
            end
            S_INC: begin
                ALU_Op_o   = OP_ADD;
                ADDR_RDA_o = R_COUNT;
                ADDR_RDB_o = R_ONE;
                ADDR_WR_o  = R_COUNT;
                WE_o       = 1'b1;
            end
            S_ODD: begin
                ALU_Op_o   = OP_ADD;
                ADDR_RDA_o = R_ODD;
                ADDR_RDB_o = R_TWO;
                ADDR_WR_o  = R_ODD;
                WE_o       = 1'b1;
            end
            S_OUT: begin
                // R2 & R2 passes the count through the ALU to the output reg.
                ALU_Op_o   = OP_AND;
                ADDR_RDA_o = R_COUNT;
                ADDR_RDB_o = R_COUNT;
                OE_o       = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
                err_o  = operand_q[MSB];
            end
            default: begin
            end
        endcase
    end

endmodule
